boid_frame_scheduler: RTL

- Sequences the per-frame rebuild of the boid display memory.
- On each VGA frame-end pulse it issues a one-cycle clear to the resettable display RAM.
- It then walks the boid index 0..N-1 over the BPU output mux and writes one pixel per boid, pipelined at one boid per cycle.
- It sits between VGAController (frame_end), the BPU bank (boid_sel / boid_addr) and RAM_resettable (we / write_addr / reset).

---
 rtl/boid_pkg.sv | 18 +
 rtl/boid_frame_scheduler.sv | 102 ++++++++++
 2 files changed

// File: rtl/boid_pkg.sv
// Shared constants and state encoding for the boid frame scheduler.
package boid_pkg;

  localparam int MAX_BOIDS    = 8;
  localparam int BOID_BITS    = 3;
  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int ADDR_W       = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/boid_frame_scheduler.sv
// Per-frame display rebuild: one-cycle RAM clear, then one pixel write per boid,
// pipelined one boid per cycle through a registered write stage.
module boid_frame_scheduler
  import boid_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_frame_end,
  input  logic [BOID_BITS:0]   i_num_boids,
  input  logic                 i_clr_overrun,
  output logic [BOID_BITS-1:0] o_boid_sel,
  input  logic [ADDR_W-1:0]    i_boid_addr,
  output logic                 o_disp_clear,
  output logic                 o_disp_we,
  output logic [ADDR_W-1:0]    o_disp_waddr,
  output logic                 o_busy,
  output logic                 o_overrun,
  output logic [15:0]          o_frames_done
);

  state_t               r_state;
  state_t               w_next;
  logic [BOID_BITS:0]   r_n;
  logic [BOID_BITS-1:0] r_sel;
  logic                 r_pending;
  logic                 r_overrun;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_waddr;
  logic [15:0]          r_frames;

  logic [BOID_BITS:0]   w_n_clamped;
  logic                 w_last;
  logic                 w_addr_ok;
  logic                 w_busy_set;

  assign w_n_clamped = (i_num_boids > (BOID_BITS+1)'(MAX_BOIDS)) ?
                       (BOID_BITS+1)'(MAX_BOIDS) : i_num_boids;
  assign w_last      = ({1'b0, r_sel} == (r_n - (BOID_BITS+1)'(1)));
  assign w_addr_ok   = (i_boid_addr < ADDR_W'(PIXEL_COUNT));
  // A frame_end landing in DRAIN simply chains the next frame, so it is not an overrun.
  assign w_busy_set  = i_frame_end && ((r_state == ST_CLEAR) || (r_state == ST_SCAN));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_frame_end) w_next = ST_CLEAR;
      ST_CLEAR: w_next = (w_n_clamped != '0) ? ST_SCAN : ST_DRAIN;
      ST_SCAN:  if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = (r_pending || i_frame_end) ? ST_CLEAR : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_n       <= '0;
      r_sel     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_frames  <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == ST_CLEAR) begin
        r_n   <= w_n_clamped;
        r_sel <= '0;
      end else if ((r_state == ST_SCAN) && !w_last) begin
        r_sel <= r_sel + (BOID_BITS)'(1);
      end

      if (r_state == ST_DRAIN)
        r_pending <= 1'b0;
      else if (w_busy_set)
        r_pending <= 1'b1;

      if (w_busy_set)
        r_overrun <= 1'b1;
      else if (i_clr_overrun)
        r_overrun <= 1'b0;

      // Off-screen addresses still update the address register but suppress the write.
      r_we <= (r_state == ST_SCAN) && w_addr_ok;
      if (r_state == ST_SCAN)
        r_waddr <= i_boid_addr;

      if (r_state == ST_DRAIN)
        r_frames <= r_frames + 16'd1;
    end
  end

  assign o_boid_sel    = r_sel;
  assign o_disp_clear  = (r_state == ST_CLEAR);
  assign o_disp_we     = r_we;
  assign o_disp_waddr  = r_waddr;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_overrun     = r_overrun;
  assign o_frames_done = r_frames;

endmodule
